// File: rtl/pcie_datalink_pkg.sv
// rtl/pcie_datalink_pkg.sv - shared DLL sequence/LCRC types and constants
package pcie_datalink_pkg;

    localparam int          SEQ_W          = 12;
    localparam int          SEQ_WINDOW     = 2048;
    localparam logic [31:0] LCRC_INIT      = 32'hFFFF_FFFF;
    // 04C11DB7 bit-reversed: the CRC register shifts LSB-first
    localparam logic [31:0] LCRC_POLY_REFL = 32'hEDB8_8320;

    typedef logic [SEQ_W-1:0] seq_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2,
        LCRC = 2'd3
    } framer_state_e;

    typedef struct packed {
        framer_state_e state;
        seq_t          next_tx_seq;
        seq_t          ackd_seq;
    } framer_regs_t;

    function automatic seq_t seq_outstanding(input seq_t next_seq, input seq_t ackd_seq);
        return next_seq - ackd_seq - seq_t'(1);
    endfunction

endpackage

// File: rtl/dll_lcrc32.sv
// rtl/dll_lcrc32.sv - CRC-32 accumulator, up to one DW per cycle, byte 0 = data_i[7:0]
module dll_lcrc32
    import pcie_datalink_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        init_i,
    input  logic        en_i,
    input  logic [31:0] data_i,
    input  logic [2:0]  nbytes_i,
    output logic [31:0] crc_o
);

    logic [31:0] r_crc;
    logic [31:0] w_next;

    // init_i folds the first bytes on top of the seed so the header beat needs no extra cycle
    always_comb begin
        w_next = init_i ? LCRC_INIT : r_crc;
        for (int i = 0; i < 32; i++) begin
            if (i < 8 * int'(nbytes_i)) begin
                if (w_next[0] ^ data_i[i]) begin
                    w_next = (w_next >> 1) ^ LCRC_POLY_REFL;
                end else begin
                    w_next = w_next >> 1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_crc <= LCRC_INIT;
        end else if (en_i) begin
            r_crc <= w_next;
        end
    end

    assign crc_o = r_crc;

endmodule

// File: rtl/dll_tx_seq_framer.sv
// rtl/dll_tx_seq_framer.sv - DLL transmit framer: seq header + TLP + LCRC toward retry FIFO
module dll_tx_seq_framer
    import pcie_datalink_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    input  logic                  m_axis_tready,
    input  logic                  ack_valid_i,
    input  logic [SEQ_W-1:0]      ack_seq_i,
    input  logic                  replay_busy_i,
    output logic [SEQ_W-1:0]      next_tx_seq_o,
    output logic [SEQ_W-1:0]      ackd_seq_o,
    output logic                  window_full_o
);

    framer_regs_t r_q;
    framer_regs_t w_d;
    seq_t         w_outstanding;
    seq_t         w_ack_dist;
    logic         w_window_full;
    logic         w_crc_init;
    logic         w_crc_en;
    logic [2:0]   w_crc_nbytes;
    logic [31:0]  w_crc_data;
    logic [31:0]  w_crc;

    assign w_outstanding = seq_outstanding(r_q.next_tx_seq, r_q.ackd_seq);
    assign w_window_full = (w_outstanding >= seq_t'(SEQ_WINDOW));
    assign w_ack_dist    = r_q.next_tx_seq - seq_t'(1) - ack_seq_i;
    assign w_crc_data    = (r_q.state == HDR) ? 32'(r_q.next_tx_seq) : s_axis_tdata[31:0];

    dll_lcrc32 u_lcrc (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .init_i   (w_crc_init),
        .en_i     (w_crc_en),
        .data_i   (w_crc_data),
        .nbytes_i (w_crc_nbytes),
        .crc_o    (w_crc)
    );

    always_comb begin
        w_d           = r_q;
        s_axis_tready = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = '0;
        w_crc_init    = 1'b0;
        w_crc_en      = 1'b0;
        w_crc_nbytes  = 3'd4;

        case (r_q.state)
            IDLE: begin
                if (s_axis_tvalid && !replay_busy_i && !w_window_full) begin
                    w_d.state = HDR;
                end
            end
            HDR: begin
                m_axis_tdata  = DATA_WIDTH'(r_q.next_tx_seq);
                m_axis_tkeep  = '1;
                m_axis_tvalid = 1'b1;
                if (m_axis_tready) begin
                    w_crc_init   = 1'b1;
                    w_crc_en     = 1'b1;
                    w_crc_nbytes = 3'd2;
                    w_d.state    = DATA;
                end
            end
            DATA: begin
                m_axis_tdata  = s_axis_tdata;
                m_axis_tkeep  = s_axis_tkeep;
                m_axis_tvalid = s_axis_tvalid;
                m_axis_tuser  = s_axis_tuser;
                s_axis_tready = m_axis_tready;
                if (s_axis_tvalid && m_axis_tready) begin
                    w_crc_en = 1'b1;
                    if (s_axis_tlast) begin
                        w_d.state = LCRC;
                    end
                end
            end
            LCRC: begin
                m_axis_tdata  = DATA_WIDTH'(~w_crc);
                m_axis_tkeep  = '1;
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = 1'b1;
                if (m_axis_tready) begin
                    w_d.next_tx_seq = r_q.next_tx_seq + seq_t'(1);
                    w_d.state       = IDLE;
                end
            end
            default: w_d.state = IDLE;
        endcase

        // Only sequence numbers actually in flight may retire; stale or future ACKs fall outside
        if (ack_valid_i && (w_ack_dist < w_outstanding)) begin
            w_d.ackd_seq = ack_seq_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_q.state       <= IDLE;
            r_q.next_tx_seq <= '0;
            r_q.ackd_seq    <= '1;
        end else begin
            r_q <= w_d;
        end
    end

    assign next_tx_seq_o = r_q.next_tx_seq;
    assign ackd_seq_o    = r_q.ackd_seq;
    assign window_full_o = w_window_full;

endmodule

// File: tb/tb_dll_tx_seq_framer.sv
// tb/tb_dll_tx_seq_framer.sv - self-checking bench for dll_tx_seq_framer
module tb_dll_tx_seq_framer;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] s_axis_tdata = '0;
    logic [3:0]  s_axis_tkeep = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic [0:0]  s_axis_tuser = '0;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic [0:0]  m_axis_tuser;
    logic        m_axis_tready = 1'b0;
    logic        ack_valid_i = 1'b0;
    logic [11:0] ack_seq_i = '0;
    logic        replay_busy_i = 1'b0;
    logic [11:0] next_tx_seq_o;
    logic [11:0] ackd_seq_o;
    logic        window_full_o;

    dll_tx_seq_framer #(.DATA_WIDTH(32), .KEEP_WIDTH(4), .USER_WIDTH(1)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready),
        .ack_valid_i(ack_valid_i), .ack_seq_i(ack_seq_i), .replay_busy_i(replay_busy_i),
        .next_tx_seq_o(next_tx_seq_o), .ackd_seq_o(ackd_seq_o), .window_full_o(window_full_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic        user;
    } beat_t;

    typedef struct {
        logic sv; logic [31:0] sd; logic sl; logic su; logic mr;
        logic ev; logic [31:0] ed; logic el; logic eu; logic er; logic [11:0] en;
    } vec_t;

    beat_t       src_q[$];
    beat_t       exp_q[$];
    beat_t       out_q[$];
    logic [11:0] m_seq;
    int          checks = 0;
    int          failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // Expected frame: hdr carries seq, LCRC covers the 2 seq bytes then every TLP byte
    task automatic add_tlp(input int ndw, input logic [31:0] seed);
        logic [31:0] c;
        logic [31:0] d;
        c = 32'hFFFF_FFFF;
        c = crc_byte(c, m_seq[7:0]);
        c = crc_byte(c, {4'h0, m_seq[11:8]});
        exp_q.push_back('{data: {20'h0, m_seq}, keep: 4'hF, last: 1'b0, user: 1'b0});
        for (int k = 0; k < ndw; k++) begin
            d = seed + 32'(k) * 32'h0103_0507;
            src_q.push_back('{data: d, keep: 4'hF, last: (k == ndw - 1), user: d[3]});
            exp_q.push_back('{data: d, keep: 4'hF, last: 1'b0, user: d[3]});
            for (int b = 0; b < 4; b++) c = crc_byte(c, d[8*b +: 8]);
        end
        exp_q.push_back('{data: ~c, keep: 4'hF, last: 1'b1, user: 1'b0});
        m_seq = m_seq + 12'd1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        s_axis_tvalid = 1'b0;
        ack_valid_i = 1'b0;
        replay_busy_i = 1'b0;
        m_axis_tready = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        m_seq = '0;
    endtask

    task automatic send_ack(input logic [11:0] seq);
        ack_valid_i = 1'b1;
        ack_seq_i = seq;
        @(posedge clk_i);
        #1;
        ack_valid_i = 1'b0;
    endtask

    task automatic hold_idle(input int n, output int highs);
        highs = 0;
        repeat (n) begin
            #1;
            if (m_axis_tvalid || s_axis_tready) highs++;
            @(posedge clk_i);
            #1;
        end
    endtask

    // Drives src_q, collects m-side beats at negedge, then counts beat mismatches vs exp_q
    task automatic run_stream(input bit stall, input bit busy_mid, input bit ack_lcrc,
                              input logic [11:0] ack_val, output int n_bad);
        int  cyc;
        bit  s_hs;
        bit  acked;
        out_q.delete();
        cyc = 0;
        acked = 1'b0;
        while ((out_q.size() < exp_q.size()) && (cyc < 2000)) begin
            if (src_q.size() == 0) begin
                s_axis_tvalid = 1'b0;
            end else begin
                if (!s_axis_tvalid) s_axis_tvalid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                s_axis_tdata = src_q[0].data;
                s_axis_tkeep = src_q[0].keep;
                s_axis_tlast = src_q[0].last;
                s_axis_tuser = src_q[0].user;
            end
            m_axis_tready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            replay_busy_i = busy_mid && (out_q.size() >= 2);
            ack_valid_i = 1'b0;
            if (ack_lcrc && !acked && m_axis_tvalid && m_axis_tlast && m_axis_tready) begin
                ack_valid_i = 1'b1;
                ack_seq_i = ack_val;
                acked = 1'b1;
            end
            #4;
            s_hs = s_axis_tvalid && s_axis_tready;
            if (m_axis_tvalid && m_axis_tready)
                out_q.push_back('{data: m_axis_tdata, keep: m_axis_tkeep,
                                  last: m_axis_tlast, user: m_axis_tuser[0]});
            @(posedge clk_i);
            #1;
            ack_valid_i = 1'b0;
            if (s_hs) begin
                void'(src_q.pop_front());
                s_axis_tvalid = 1'b0;
            end
            cyc++;
        end
        s_axis_tvalid = 1'b0;
        replay_busy_i = 1'b0;
        m_axis_tready = 1'b1;
        n_bad = (out_q.size() != exp_q.size()) ? 1 : 0;
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
            if (out_q[i] !== exp_q[i]) n_bad++;
        exp_q.delete();
        src_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        tbl[10];
        int          nb;
        int          bulk;
        int          highs;
        int          nlast;
        logic [31:0] lc;

        m_seq = '0;
        s_axis_tvalid = 1'b1;
        do_reset();
        #1;
        check("rst_m_tvalid", 32'(m_axis_tvalid), 0);
        check("rst_s_tready", 32'(s_axis_tready), 0);
        check("rst_m_tdata", m_axis_tdata, 0);
        check("rst_m_tlast", 32'(m_axis_tlast), 0);
        check("rst_next_seq", 32'(next_tx_seq_o), 0);
        check("rst_ackd_seq", 32'(ackd_seq_o), 32'hFFF);
        check("rst_window_full", 32'(window_full_o), 0);
        @(posedge clk_i);
        #1;

        add_tlp(3, 32'hA1B2_C3D4);
        lc = exp_q[4].data;
        tbl[0] = '{1, src_q[0].data, 0, src_q[0].user, 1, 0, 32'h0, 0, 0, 0, 12'd0};
        tbl[1] = '{1, src_q[0].data, 0, src_q[0].user, 0, 1, 32'h0, 0, 0, 0, 12'd0};
        tbl[2] = '{1, src_q[0].data, 0, src_q[0].user, 1, 1, 32'h0, 0, 0, 0, 12'd0};
        tbl[3] = '{1, src_q[0].data, 0, src_q[0].user, 1, 1, src_q[0].data, 0, src_q[0].user, 1, 12'd0};
        tbl[4] = '{1, src_q[1].data, 0, src_q[1].user, 0, 1, src_q[1].data, 0, src_q[1].user, 0, 12'd0};
        tbl[5] = '{1, src_q[1].data, 0, src_q[1].user, 1, 1, src_q[1].data, 0, src_q[1].user, 1, 12'd0};
        tbl[6] = '{1, src_q[2].data, 1, src_q[2].user, 1, 1, src_q[2].data, 0, src_q[2].user, 1, 12'd0};
        tbl[7] = '{0, src_q[2].data, 0, 0, 0, 1, lc, 1, 0, 0, 12'd0};
        tbl[8] = '{0, src_q[2].data, 0, 0, 1, 1, lc, 1, 0, 0, 12'd0};
        tbl[9] = '{0, src_q[2].data, 0, 0, 1, 0, 32'h0, 0, 0, 0, 12'd1};
        src_q.delete();
        exp_q.delete();
        for (int i = 0; i < 10; i++) begin
            s_axis_tvalid = tbl[i].sv;
            s_axis_tdata  = tbl[i].sd;
            s_axis_tlast  = tbl[i].sl;
            s_axis_tuser  = tbl[i].su;
            s_axis_tkeep  = 4'hF;
            m_axis_tready = tbl[i].mr;
            #1;
            check($sformatf("vec%0d_m_tvalid", i), 32'(m_axis_tvalid), 32'(tbl[i].ev));
            check($sformatf("vec%0d_s_tready", i), 32'(s_axis_tready), 32'(tbl[i].er));
            check($sformatf("vec%0d_next_seq", i), 32'(next_tx_seq_o), 32'(tbl[i].en));
            if (tbl[i].ev) begin
                check($sformatf("vec%0d_m_tdata", i), m_axis_tdata, tbl[i].ed);
                check($sformatf("vec%0d_m_tlast", i), 32'(m_axis_tlast), 32'(tbl[i].el));
                check($sformatf("vec%0d_m_tuser", i), 32'(m_axis_tuser), 32'(tbl[i].eu));
                check($sformatf("vec%0d_m_tkeep", i), 32'(m_axis_tkeep), 32'hF);
            end
            @(posedge clk_i);
            #1;
        end

        do_reset();
        add_tlp(2, 32'h1111_0000);
        add_tlp(3, 32'h2222_0000);
        run_stream(0, 0, 0, 12'h0, nb);
        check("b2b_stream_mismatches", 32'(nb), 0);
        check("b2b_hdr0", out_q[0].data, 32'h0000_0000);
        check("b2b_hdr1", out_q[4].data, 32'h0000_0001);
        nlast = 0;
        foreach (out_q[i]) if (out_q[i].last) nlast++;
        check("b2b_tlast_count", 32'(nlast), 2);
        check("b2b_tlast_on_lcrc", 32'(out_q[3].last), 1);

        add_tlp(1, 32'h3333_0001);
        add_tlp(4, 32'h4444_0002);
        add_tlp(2, 32'h5555_0003);
        run_stream(1, 0, 0, 12'h0, nb);
        check("stall_stream_mismatches", 32'(nb), 0);
        check("stall_next_seq", 32'(next_tx_seq_o), 5);

        send_ack(12'h500);
        check("ack_stale_ignored", 32'(ackd_seq_o), 32'hFFF);
        send_ack(12'h005);
        check("ack_future_ignored", 32'(ackd_seq_o), 32'hFFF);
        send_ack(12'h002);
        check("ack_accepted", 32'(ackd_seq_o), 2);
        send_ack(12'h001);
        check("ack_older_ignored", 32'(ackd_seq_o), 2);
        add_tlp(1, 32'h6666_0004);
        run_stream(0, 0, 1, 12'h004, nb);
        check("ack_lcrc_stream", 32'(nb), 0);
        check("ack_lcrc_next_seq", 32'(next_tx_seq_o), 6);
        check("ack_lcrc_ackd_seq", 32'(ackd_seq_o), 4);

        add_tlp(3, 32'h7777_0005);
        replay_busy_i = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = src_q[0].data;
        s_axis_tlast  = src_q[0].last;
        hold_idle(4, highs);
        check("replay_blocks_start", 32'(highs), 0);
        replay_busy_i = 1'b0;
        run_stream(0, 1, 0, 12'h0, nb);
        check("replay_mid_frame_completes", 32'(nb), 0);

        do_reset();
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'hDEAD_BEEF;
        s_axis_tlast  = 1'b0;
        repeat (3) begin
            @(posedge clk_i);
            #1;
        end
        check("midrst_in_data", 32'(m_axis_tvalid && s_axis_tready), 1);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        s_axis_tvalid = 1'b0;
        #1;
        check("midrst_m_tvalid", 32'(m_axis_tvalid), 0);
        check("midrst_s_tready", 32'(s_axis_tready), 0);
        check("midrst_next_seq", 32'(next_tx_seq_o), 0);
        @(posedge clk_i);
        #1;
        m_seq = '0;
        add_tlp(2, 32'h8888_0006);
        run_stream(0, 0, 0, 12'h0, nb);
        check("midrst_new_frame", 32'(nb), 0);
        send_ack(12'h000);

        bulk = 0;
        for (int i = 1; i < 4095; i++) begin
            add_tlp(1, 32'(i));
            run_stream(0, 0, 0, 12'h0, nb);
            bulk += nb;
            send_ack(m_seq - 12'd1);
        end
        check("wrap_bulk_frames", 32'(bulk), 0);
        check("wrap_pre_next_seq", 32'(next_tx_seq_o), 32'hFFF);
        check("wrap_pre_window_full", 32'(window_full_o), 0);
        add_tlp(2, 32'h9999_0007);
        run_stream(0, 0, 0, 12'h0, nb);
        check("wrap_frame_fff", 32'(nb), 0);
        check("wrap_hdr_fff", out_q[0].data, 32'h0000_0FFF);
        check("wrap_next_seq_zero", 32'(next_tx_seq_o), 0);
        send_ack(12'hFFF);
        bulk = 0;
        for (int i = 0; i < 16; i++) begin
            add_tlp(1, 32'hAAAA_0000 + 32'(i));
            run_stream(0, 0, 0, 12'h0, nb);
            if (i == 0) check("wrap_hdr_000", out_q[0].data, 32'h0000_0000);
            bulk += nb;
            send_ack(m_seq - 12'd1);
        end
        check("post_wrap_frames", 32'(bulk), 0);
        check("post_wrap_next", 32'(next_tx_seq_o), 32'h010);
        check("post_wrap_ackd", 32'(ackd_seq_o), 32'h00F);
        send_ack(12'h500);
        check("ack_500_stale", 32'(ackd_seq_o), 32'h00F);

        do_reset();
        bulk = 0;
        for (int i = 0; i < 2048; i++) begin
            add_tlp(1, 32'hC000_0000 + 32'(i));
            run_stream(0, 0, 0, 12'h0, nb);
            bulk += nb;
        end
        check("window_bulk_frames", 32'(bulk), 0);
        check("window_full_set", 32'(window_full_o), 1);
        check("window_next_seq", 32'(next_tx_seq_o), 32'h800);
        add_tlp(1, 32'hD000_0001);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = src_q[0].data;
        s_axis_tlast  = src_q[0].last;
        s_axis_tuser  = src_q[0].user;
        hold_idle(8, highs);
        check("window_stalls_2049", 32'(highs), 0);
        send_ack(12'h000);
        check("window_ack0_ackd", 32'(ackd_seq_o), 0);
        check("window_full_cleared", 32'(window_full_o), 0);
        run_stream(0, 0, 0, 12'h0, nb);
        check("window_resumes", 32'(nb), 0);
        check("window_resume_hdr", out_q[0].data, 32'h0000_0800);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
